// File: rtl/id_pool.sv
`default_nettype none
// ----------------------------------------------------------------------------
// id_pool : circular free-list allocator for instruction IDs with multi-port
//           release. Define ID_POOL_CHECK_EN to drop and flag bogus retires.
// Revision: 1.0
// ----------------------------------------------------------------------------
module id_pool #(
    parameter  int MAX_IDS      = 8,
    parameter  int RETIRE_PORTS = 2,
    localparam int ID_W         = $clog2(MAX_IDS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         alloc_req,
    output logic                         alloc_valid,
    output logic [ID_W-1:0]              alloc_id,
    input  logic [RETIRE_PORTS-1:0]      retire_valid,
    input  logic [RETIRE_PORTS*ID_W-1:0] retire_id,
    output logic [ID_W:0]                free_count,
    output logic                         all_free,
    output logic                         error
);

    localparam logic [ID_W:0] c_FULL = (ID_W+1)'(MAX_IDS);

    logic [ID_W-1:0]         r_ring [MAX_IDS];
    logic [ID_W-1:0]         r_rd_ptr;
    logic [ID_W-1:0]         r_wr_ptr;
    logic [ID_W:0]           r_cnt;
    logic                    r_error;

    logic                    w_pop;
    logic [ID_W:0]           w_room;
    logic [ID_W:0]           w_acc_cnt;
    logic [RETIRE_PORTS-1:0] w_acc;
    logic [ID_W-1:0]         w_slot [RETIRE_PORTS];
    logic                    w_drop;
    logic                    w_ok;
`ifdef ID_POOL_CHECK_EN
    logic [MAX_IDS-1:0]      r_in_flight;
    logic [MAX_IDS-1:0]      w_clr;
    logic [ID_W-1:0]         w_rid;
`endif

    // Room counts the slot freed by a same-cycle pop, so cnt never exceeds MAX_IDS.
    always_comb begin
        w_pop     = alloc_req && (r_cnt != '0);
        w_room    = c_FULL - r_cnt + {{ID_W{1'b0}}, w_pop};
        w_acc_cnt = '0;
        w_acc     = '0;
        w_drop    = 1'b0;
        w_ok      = 1'b0;
`ifdef ID_POOL_CHECK_EN
        w_clr     = '0;
        w_rid     = '0;
`endif
        for (int p = 0; p < RETIRE_PORTS; p++) begin
            w_slot[p] = r_wr_ptr + w_acc_cnt[ID_W-1:0];
            if (retire_valid[p]) begin
`ifdef ID_POOL_CHECK_EN
                w_rid = retire_id[p*ID_W +: ID_W];
                w_ok  = r_in_flight[w_rid] && !w_clr[w_rid];
`else
                w_ok  = 1'b1;
`endif
                if (w_ok && (w_acc_cnt < w_room)) begin
                    w_acc[p]  = 1'b1;
                    w_acc_cnt = w_acc_cnt + (ID_W+1)'(1);
`ifdef ID_POOL_CHECK_EN
                    w_clr[w_rid] = 1'b1;
`endif
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_IDS; i++) begin
                r_ring[i] <= ID_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= c_FULL;
            r_error  <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < MAX_IDS; i++) begin
                r_ring[i] <= ID_W'(i);
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= c_FULL;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ID_W'(1);
            end
            for (int p = 0; p < RETIRE_PORTS; p++) begin
                if (w_acc[p]) begin
                    r_ring[w_slot[p]] <= retire_id[p*ID_W +: ID_W];
                end
            end
            r_wr_ptr <= r_wr_ptr + w_acc_cnt[ID_W-1:0];
            r_cnt    <= r_cnt - {{ID_W{1'b0}}, w_pop} + w_acc_cnt;
            if (w_drop) begin
                r_error <= 1'b1;
            end
        end
    end

`ifdef ID_POOL_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
        end else if (flush) begin
            r_in_flight <= '0;
        end else begin
            r_in_flight <= (r_in_flight | (w_pop ? (MAX_IDS'(1) << alloc_id) : '0)) & ~w_clr;
        end
    end
`endif

    assign alloc_valid = (r_cnt != '0);
    assign alloc_id    = r_ring[r_rd_ptr];
    assign free_count  = r_cnt;
    assign all_free    = (r_cnt == c_FULL);
    assign error       = r_error;

endmodule
`default_nettype wire

// File: doc/id_pool.md
Name: id_pool

Overview:
- Parametrised instruction-ID allocator; successor to the fixed MAX_IDS/COMMIT_PORTS settings.
- Holds a circular free-list of IDs.
- Issue/decode pops one ID per cycle. Up to RETIRE_PORTS commit ports return IDs per cycle.
- Sits between decode (allocation) and writeback/commit (release).

Parameters:
- MAX_IDS, 8, number of IDs; power of 2, minimum 2
- RETIRE_PORTS, 2, number of simultaneous release ports; 1..MAX_IDS
- ID_W, $clog2(MAX_IDS), ID width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  return all IDs to pool, synchronous
- alloc_req  in  1  consumer takes alloc_id this cycle
- alloc_valid  out  1  an ID is available
- alloc_id  out  ID_W  ID at head of free-list
- retire_valid  in  RETIRE_PORTS  per-port release strobe
- retire_id  in  RETIRE_PORTS*ID_W  per-port released ID; port p at [p*ID_W +: ID_W]
- free_count  out  ID_W+1  number of free IDs, 0..MAX_IDS
- all_free  out  1  free_count == MAX_IDS
- error  out  1  sticky misuse flag (see Optional Feature)

Behaviour:
- Storage: MAX_IDS-entry ring of ID_W entries, read pointer rd_ptr, write pointer wr_ptr (ID_W bits each), counter cnt (ID_W+1 bits). Pointers wrap modulo MAX_IDS naturally.
- Reset (rst_n low, async):
  - ring[i] = i
  - rd_ptr = 0, wr_ptr = 0, cnt = MAX_IDS
  - Outputs: alloc_valid=1, alloc_id=0, free_count=MAX_IDS, all_free=1, error=0
- Outputs:
  - alloc_valid = (cnt != 0), alloc_id = ring[rd_ptr]; both registered-state driven, no input-to-output combinational paths.
  - free_count = cnt; all_free = (cnt == MAX_IDS).
- Allocation: pop occurs when alloc_req && alloc_valid. rd_ptr+1, ID leaves the pool. alloc_req with alloc_valid=0 is ignored and does not set error.
- Release:
  - Ports are accepted in ascending port order.
  - Accepted port k writes retire_id[k] to ring[wr_ptr + k'], where k' is the number of accepted ports below k.
  - wr_ptr and cnt advance by the accepted count.
- Same-cycle events:
  - cnt_next = cnt - pop + accepted_retires.
  - No bypass: an ID released in cycle N is allocatable no earlier than cycle N+1, even when cnt==0.
- Overflow: a retire that would push cnt above MAX_IDS is dropped (excess ports in port order) and sets error.
- Flush (synchronous, highest priority):
  - Next cycle: ring[i]=i, rd_ptr=0, wr_ptr=0, cnt=MAX_IDS.
  - Same-cycle alloc and retire are ignored. error is unchanged.
- Reset mid-operation: async rst_n overrides everything immediately, including a flush in progress.
- Latency: 1 cycle from release strobe to free_count update and to availability.

Optional Feature:
- Macro: ID_POOL_CHECK_EN
- Defined:
  - Add MAX_IDS-bit in_flight vector; reset/flush clear it to 0.
  - Pop sets in_flight[alloc_id].
  - A retire of an ID with in_flight=0, or the same ID on two ports in one cycle (the second occurrence), is dropped and sets error.
  - Valid retires clear their bit.
  - error is sticky until rst_n.
- Undefined:
  - No in_flight vector.
  - Retires are accepted unchecked.
  - error is set only by overflow.

Test Plan:
- Reset, then alloc_req held 8 cycles -> alloc_id 0,1,...,7 in order; after 8th pop alloc_valid=0, free_count=0; 9th alloc_req ignored, error=0.
- Pool empty; retire ports 0,1 release IDs 5 and 2 in one cycle with alloc_req=1 -> no pop that cycle; next cycle free_count=2, alloc_id=5, then 2.
- free_count=4 (IDs 4..7 allocated); same cycle pop ID and retire IDs 4,6 -> next cycle free_count=5; later allocation order ends ...,4,6.
- Run 20 alloc/retire cycles crossing ring wrap (pointers pass 7->0) -> IDs never duplicated among outstanding, free_count consistent with the model each cycle.
- flush asserted together with alloc_req and retire_valid=2'b11 -> next cycle free_count=8, all_free=1, alloc_id=0.
- ID_POOL_CHECK_EN: retire ID 3 never allocated, or ID 1 on both ports -> retire dropped, error=1 held until rst_n. Without macro: full pool plus retire -> dropped, error=1.
